drum_audio_bridge: RTL and testbench
====================================

// Module: drum_audio_bridge
// PURPOSE
// - Consumer/controller end of the drum column array: waits for all columns to reach ITERATION_DONE,
//   captures the centre-node amplitude, and re-arms the columns with a one-cycle iteration_enable.
// - Converts each captured sample to 32-bit audio and writes it to the audio core FIFO
//   (left, then right) over an Avalon-MM master. It writes only when both FIFOs report space.
// PARAMETERS
// - AUDIO_BASE   32'hFF203040  byte address of the audio core; fifospace at +4, left at +8, right at +12
// - AUDIO_SHIFT  14            left shift applied to the sign-extended 1.17 node to form the sample
// PORTS
// - clk              in   1   system clock
// - reset            in   1   synchronous, active-high reset
// - run              in   1   level; 0 = finish current sample, then hold columns in ITERATION_DONE
// - iteration_done   in   1   AND of all column ITERATION_DONE flags
// - center_node      in   18  signed 1.17 centre-node amplitude
// - iteration_enable out  1   one-cycle pulse that starts the next column iteration
// - bus_address      out  32  Avalon byte address
// - bus_read         out  1   Avalon read request
// - bus_write        out  1   Avalon write request
// - bus_writedata    out  32  Avalon write data
// - bus_readdata     in   32  Avalon read data; valid in the cycle bus_waitrequest=0 while bus_read=1
// - bus_waitrequest  in   1   Avalon stall
// - sample_count     out  32  number of samples written to the FIFO (right-channel write completions)
// BEHAVIOUR
// - Reset values: all outputs 0; state WAIT_DONE; sample register 0. Reset mid-transfer drops
//   bus_read/bus_write in the next cycle. No partial sample is resumed.
// - States and transitions:
//   - WAIT_DONE: if run & iteration_done -> CAPTURE; otherwise stay.
//   - CAPTURE: sample <= {{14{c[17]}},c} <<< AUDIO_SHIFT (c = center_node); -> RELEASE.
//   - RELEASE: iteration_enable=1 for exactly this cycle; -> RD_SPACE.
//   - RD_SPACE: bus_read=1, bus_address=AUDIO_BASE+4. Held until bus_waitrequest=0.
//     - On accept: if readdata[31:24]!=0 and [23:16]!=0 -> WR_LEFT; else -> RD_SPACE, re-polling
//       from the next cycle with bus_read dropped for 1 cycle.
//   - WR_LEFT: bus_write=1, address=AUDIO_BASE+8, writedata=sample; held until waitrequest=0; -> WR_RIGHT.
//   - WR_RIGHT: same with address=AUDIO_BASE+12; on accept sample_count++ (wraps at 2^32); -> WAIT_DONE.
// - Column computation overlaps the audio write, because iteration_enable fires before the FIFO transfer.
// - iteration_done is sampled only in WAIT_DONE. The stale done seen in the cycles right after RELEASE
//   is therefore never acted on. Minimum gap between RELEASE pulses is 5 cycles.
// - bus_read and bus_write are never both 1. Address and writedata are stable while a request is stalled.
// - run falling mid-sequence: the current sample completes; the FSM then parks in WAIT_DONE.
// - Saturation: none. The shift is arithmetic, and the sign of center_node is preserved for AUDIO_SHIFT<=14.
// CONFIGURATION
// - DRUM_CYCLE_STATS_EN defined: extra outputs iter_cycles[15:0] and max_iter_cycles[15:0].
//   - Counter clears on RELEASE and increments each cycle until iteration_done is seen in WAIT_DONE.
//   - It then latches into iter_cycles and updates max_iter_cycles if larger. Both outputs reset to 0.
//   - The counter saturates at 16'hFFFF.
// - Not defined: those ports and the counter logic do not exist; the rest is unchanged.
// TESTING
// - Reset, run=1, done=1, center=18'h10000, FIFO space 0x0101_0000, waitrequest=0:
//   - iteration_enable pulses 2 cycles after reset release.
//   - Writes 32'h4000_0000 to +8 then +12; sample_count=1.
// - center=18'h3FFFF (-1 lsb): writedata=32'hFFFF_C000 on both channels.
// - fifospace reads 0x0000_0000 three times, then 0x0101_0000:
//   - four reads are issued, then two writes; no write occurs before space is reported.
// - waitrequest held 1 for 3 cycles on each access:
//   - address, data and request stay stable; exactly one read and two writes are accepted.
// - done held 1 continuously:
//   - exactly one iteration_enable per sample; RELEASE pulses are at least 5 cycles apart.
// - run=0 asserted during WR_LEFT: WR_RIGHT completes, then no further iteration_enable.
//   - Reset asserted during WR_LEFT: bus_write=0 the next cycle; sample_count=0.

Source files
------------

// File: rtl/drum_audio_bridge.sv
// Drum column controller and audio FIFO writer: re-arms the column array and streams the centre node to the audio core.
// Optional build macro DRUM_CYCLE_STATS_EN adds iteration cycle statistics outputs.
module drum_audio_bridge #(
    parameter logic [31:0] AUDIO_BASE  = 32'hFF20_3040,
    parameter int unsigned AUDIO_SHIFT = 14
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        run_i,
    input  logic        iteration_done_i,
    input  logic [17:0] center_node_i,
    output logic        iteration_enable_o,
    output logic [31:0] bus_address_o,
    output logic        bus_read_o,
    output logic        bus_write_o,
    output logic [31:0] bus_writedata_o,
    input  logic [31:0] bus_readdata_i,
    input  logic        bus_waitrequest_i,
    output logic [31:0] sample_count_o
`ifdef DRUM_CYCLE_STATS_EN
    ,
    output logic [15:0] iter_cycles_o,
    output logic [15:0] max_iter_cycles_o
`endif
);

    // state      | meaning
    // WAIT_DONE  | idle until run and all columns report ITERATION_DONE
    // CAPTURE    | latch scaled centre node into the sample register
    // RELEASE    | one-cycle iteration_enable, columns start next step
    // RD_SPACE   | poll fifospace until both channels have room
    // WR_LEFT    | write sample to the left FIFO
    // WR_RIGHT   | write sample to the right FIFO, count the sample
    typedef enum logic [2:0] {
        S_WAIT_DONE,
        S_CAPTURE,
        S_RELEASE,
        S_RD_SPACE,
        S_WR_LEFT,
        S_WR_RIGHT
    } state_t;

    localparam logic [31:0] ADDR_SPACE = AUDIO_BASE + 32'd4;
    localparam logic [31:0] ADDR_LEFT  = AUDIO_BASE + 32'd8;
    localparam logic [31:0] ADDR_RIGHT = AUDIO_BASE + 32'd12;

    state_t      state_q;
    logic [31:0] sample_q;
    logic        iteration_enable_q;
    logic        bus_read_q;
    logic        bus_write_q;
    logic [31:0] bus_address_q;
    logic [31:0] bus_writedata_q;
    logic [31:0] sample_count_q;

    logic [31:0] center_sext;
    logic [31:0] sample_d;
    logic [31:0] sample_count_d;
    logic        space_ok;
    logic        bus_accept;
    logic        unused_readdata;

    assign center_sext    = {{14{center_node_i[17]}}, center_node_i};
    assign sample_d       = center_sext << AUDIO_SHIFT;
    assign sample_count_d = sample_count_q + 32'd1;
    // Only the write-space bytes matter; the read-space half of fifospace is ignored.
    assign space_ok       = (bus_readdata_i[31:24] != 8'd0) && (bus_readdata_i[23:16] != 8'd0);
    assign bus_accept     = ~bus_waitrequest_i;
    assign unused_readdata = ^bus_readdata_i[15:0];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q            <= S_WAIT_DONE;
            sample_q           <= '0;
            iteration_enable_q <= 1'b0;
            bus_read_q         <= 1'b0;
            bus_write_q        <= 1'b0;
            bus_address_q      <= '0;
            bus_writedata_q    <= '0;
            sample_count_q     <= '0;
        end else begin
            iteration_enable_q <= 1'b0;
            unique case (state_q)
                S_WAIT_DONE: begin
                    if (run_i && iteration_done_i) begin
                        state_q <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    sample_q           <= sample_d;
                    iteration_enable_q <= 1'b1;
                    state_q            <= S_RELEASE;
                end
                S_RELEASE: begin
                    bus_read_q    <= 1'b1;
                    bus_address_q <= ADDR_SPACE;
                    state_q       <= S_RD_SPACE;
                end
                S_RD_SPACE: begin
                    // A refused poll leaves bus_read low for one cycle before asking again.
                    if (!bus_read_q) begin
                        bus_read_q <= 1'b1;
                    end else if (bus_accept) begin
                        bus_read_q <= 1'b0;
                        if (space_ok) begin
                            bus_write_q     <= 1'b1;
                            bus_address_q   <= ADDR_LEFT;
                            bus_writedata_q <= sample_q;
                            state_q         <= S_WR_LEFT;
                        end
                    end
                end
                S_WR_LEFT: begin
                    if (bus_accept) begin
                        bus_address_q <= ADDR_RIGHT;
                        state_q       <= S_WR_RIGHT;
                    end
                end
                S_WR_RIGHT: begin
                    if (bus_accept) begin
                        bus_write_q    <= 1'b0;
                        bus_address_q  <= '0;
                        sample_count_q <= sample_count_d;
                        state_q        <= S_WAIT_DONE;
                    end
                end
                default: begin
                    state_q     <= S_WAIT_DONE;
                    bus_read_q  <= 1'b0;
                    bus_write_q <= 1'b0;
                end
            endcase
        end
    end

    assign iteration_enable_o = iteration_enable_q;
    assign bus_address_o      = bus_address_q;
    assign bus_read_o         = bus_read_q;
    assign bus_write_o        = bus_write_q;
    assign bus_writedata_o    = bus_writedata_q;
    assign sample_count_o     = sample_count_q;

`ifdef DRUM_CYCLE_STATS_EN
    logic [15:0] cyc_cnt_q;
    logic        counting_q;
    logic [15:0] iter_cycles_q;
    logic [15:0] max_iter_cycles_q;

    // Measures RELEASE-to-done latency of the column array, saturating at all ones.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cyc_cnt_q         <= '0;
            counting_q        <= 1'b0;
            iter_cycles_q     <= '0;
            max_iter_cycles_q <= '0;
        end else if (state_q == S_RELEASE) begin
            cyc_cnt_q  <= '0;
            counting_q <= 1'b1;
        end else if (counting_q) begin
            if ((state_q == S_WAIT_DONE) && iteration_done_i) begin
                counting_q    <= 1'b0;
                iter_cycles_q <= cyc_cnt_q;
                if (cyc_cnt_q > max_iter_cycles_q) begin
                    max_iter_cycles_q <= cyc_cnt_q;
                end
            end else if (cyc_cnt_q != 16'hFFFF) begin
                cyc_cnt_q <= cyc_cnt_q + 16'd1;
            end
        end
    end

    assign iter_cycles_o     = iter_cycles_q;
    assign max_iter_cycles_o = max_iter_cycles_q;
`endif

endmodule

// File: tb/tb_drum_audio_bridge.sv
// Directed bench for drum_audio_bridge: Avalon slave model with stall/space control and a write scoreboard.
`timescale 1ns/1ps
module tb_drum_audio_bridge;

    localparam logic [31:0] BASE     = 32'hFF20_3040;
    localparam logic [31:0] SPACE_OK = 32'h0101_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        done;
    logic [17:0] center;
    logic        ien;
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] rdata = '0;
    logic        waitreq = 1'b0;
    logic [31:0] scount;
`ifdef DRUM_CYCLE_STATS_EN
    logic [15:0] iter_cycles;
    logic [15:0] max_iter_cycles;
`endif

    always #5 clk = ~clk;

    drum_audio_bridge dut (
        .clk_i              (clk),
        .reset_i            (reset),
        .run_i              (run),
        .iteration_done_i   (done),
        .center_node_i      (center),
        .iteration_enable_o (ien),
        .bus_address_o      (addr),
        .bus_read_o         (rd),
        .bus_write_o        (wr),
        .bus_writedata_o    (wdata),
        .bus_readdata_i     (rdata),
        .bus_waitrequest_i  (waitreq),
        .sample_count_o     (scount)
`ifdef DRUM_CYCLE_STATS_EN
        ,
        .iter_cycles_o      (iter_cycles),
        .max_iter_cycles_o  (max_iter_cycles)
`endif
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] space_q[$];
    wr_t         e_w;

    int     tests = 0;
    int     failed = 0;
    int     wait_n = 0;
    int     stall = 0;
    bit     held = 0;
    logic [31:0] held_addr;
    logic [31:0] held_data;
    logic   held_rd;
    logic   held_wr;
    int     n_reads = 0;
    int     n_writes = 0;
    int     n_pulses = 0;
    longint cyc = 0;
    longint last_pulse = -1;
    bit     space_seen = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic push_pair(input logic [31:0] d);
        exp_q.push_back('{BASE + 32'd8, d});
        exp_q.push_back('{BASE + 32'd12, d});
    endtask

    task automatic wait_count(input logic [31:0] target, input int budget);
        int n = 0;
        while (scount !== target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("sample_count_reached", scount, target);
    endtask

    task automatic wait_ien(input int budget);
        int n = 0;
        while (ien !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("iteration_enable_seen", {31'b0, ien}, 32'd1);
    endtask

    task automatic wait_wr_left(input int budget);
        int n = 0;
        while (!(wr === 1'b1 && addr === BASE + 32'd8) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wr_left_seen", {31'b0, wr}, 32'd1);
    endtask

    task automatic do_sample(input logic [17:0] c, input logic [31:0] d);
        logic [31:0] c0;
        c0 = scount;
        center = c;
        push_pair(d);
        done = 1'b1;
        wait_ien(100);
        done = 1'b0;
        wait_count(c0 + 32'd1, 200);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    endtask

    // Avalon slave: decides stall/accept at the falling edge for the next rising edge.
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            waitreq = 1'b0;
            stall   = 0;
            held    = 0;
        end else begin
            check("rd_wr_exclusive", {31'b0, rd & wr}, 32'd0);
            if (rd || wr) begin
                if (held) begin
                    check("stall_addr_stable", addr, held_addr);
                    check("stall_req_stable", {30'b0, rd, wr}, {30'b0, held_rd, held_wr});
                    if (wr) check("stall_data_stable", wdata, held_data);
                end
                if (stall < wait_n) begin
                    waitreq   = 1'b1;
                    stall++;
                    held      = 1;
                    held_addr = addr;
                    held_data = wdata;
                    held_rd   = rd;
                    held_wr   = wr;
                end else begin
                    waitreq = 1'b0;
                    stall   = 0;
                    held    = 0;
                    if (rd) begin
                        n_reads++;
                        check("read_addr", addr, BASE + 32'd4);
                        rdata = (space_q.size() > 0) ? space_q.pop_front() : SPACE_OK;
                        if (rdata[31:24] != 8'd0 && rdata[23:16] != 8'd0) space_seen = 1;
                    end
                    if (wr) begin
                        n_writes++;
                        check("write_after_space", {31'b0, space_seen}, 32'd1);
                        check("write_expected", 32'(exp_q.size() != 0), 32'd1);
                        if (exp_q.size() > 0) begin
                            e_w = exp_q.pop_front();
                            check("write_addr", addr, e_w.a);
                            check("write_data", wdata, e_w.d);
                        end
                    end
                end
            end else begin
                waitreq = 1'b0;
                stall   = 0;
                held    = 0;
            end
            if (ien) begin
                n_pulses++;
                if (last_pulse >= 0) check("release_gap_ge5", 32'(cyc - last_pulse >= 5), 32'd1);
                last_pulse = cyc;
                space_seen = 0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, w0, p0;
        logic [31:0] c0;
        reset = 1'b1; run = 1'b0; done = 1'b0; center = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ien", {31'b0, ien}, 32'd0);
        check("rst_rd", {31'b0, rd}, 32'd0);
        check("rst_wr", {31'b0, wr}, 32'd0);
        check("rst_addr", addr, 32'd0);
        check("rst_wdata", wdata, 32'd0);
        check("rst_count", scount, 32'd0);

        // first sample straight out of reset, enable two cycles after release
        run = 1'b1; done = 1'b1; center = 18'h10000;
        push_pair(32'h4000_0000);
        w0 = n_writes;
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("ien_after_1", {31'b0, ien}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("ien_after_2", {31'b0, ien}, 32'd1);
        done = 1'b0;
        wait_count(32'd1, 200);
        check("first_writes", 32'(n_writes - w0), 32'd2);
        check("first_drained", 32'(exp_q.size()), 32'd0);

        // minus one lsb
        w0 = n_writes;
        do_sample(18'h3FFFF, 32'hFFFF_C000);
        check("neg_writes", 32'(n_writes - w0), 32'd2);

        // FIFO full three times before space appears
        r0 = n_reads; w0 = n_writes;
        space_q.push_back(32'h0000_0000);
        space_q.push_back(32'h0000_0000);
        space_q.push_back(32'h0000_0000);
        space_q.push_back(SPACE_OK);
        do_sample(18'h00001, 32'h0000_4000);
        check("poll_reads", 32'(n_reads - r0), 32'd4);
        check("poll_writes", 32'(n_writes - w0), 32'd2);

        // three stall cycles on every access
        wait_n = 3;
        r0 = n_reads; w0 = n_writes;
        do_sample(18'h20000, 32'h8000_0000);
        check("stall_reads", 32'(n_reads - r0), 32'd1);
        check("stall_writes", 32'(n_writes - w0), 32'd2);
        wait_n = 0;

        // done held high: one enable per sample
        p0 = n_pulses; c0 = scount;
        center = 18'h0ABCD;
        push_pair(32'h2AF3_4000);
        push_pair(32'h2AF3_4000);
        push_pair(32'h2AF3_4000);
        done = 1'b1;
        wait_count(c0 + 32'd3, 300);
        done = 1'b0;
        repeat (10) @(negedge clk);
        check("held_done_pulses", 32'(n_pulses - p0), 32'd3);
        check("held_done_drained", 32'(exp_q.size()), 32'd0);

        // run drops during the left write
        p0 = n_pulses; c0 = scount;
        center = 18'h3FF00;
        push_pair(32'hFFC0_0000);
        done = 1'b1;
        wait_wr_left(100);
        run = 1'b0;
        wait_count(c0 + 32'd1, 100);
        repeat (20) @(negedge clk);
        check("run_off_pulses", 32'(n_pulses - p0), 32'd1);
        check("run_off_rd", {31'b0, rd}, 32'd0);
        check("run_off_wr", {31'b0, wr}, 32'd0);
        check("run_off_drained", 32'(exp_q.size()), 32'd0);
        done = 1'b0;
        run = 1'b1;

        // reset during a stalled left write
        wait_n = 3;
        center = 18'h00010;
        done = 1'b1;
        wait_wr_left(100);
        reset = 1'b1;
        done = 1'b0;
        @(negedge clk);
        check("mid_rst_wr", {31'b0, wr}, 32'd0);
        check("mid_rst_rd", {31'b0, rd}, 32'd0);
        check("mid_rst_count", scount, 32'd0);
        reset = 1'b0;
        wait_n = 0;
        repeat (5) @(negedge clk);
        check("final_idle_wr", {31'b0, wr}, 32'd0);
        check("final_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
